// File: rtl/spi_pkg.sv
// Shared definitions for the 10-bit command SPI link (master and slave sides).
package spi_pkg;

    localparam int unsigned CMD_W  = 10;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned TYPE_W = 2;

    localparam logic [TYPE_W-1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [TYPE_W-1:0] CMD_WR_DATA = 2'b01;
    localparam logic [TYPE_W-1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [TYPE_W-1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHIFT_CMD = 3'd1,
        ST_TURN      = 3'd2,
        ST_RECV      = 3'd3,
        ST_GAP       = 3'd4
    } spi_state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: idles low, toggles every SCLK_DIV clk cycles while enabled.
// The strobes mark the clk edge on which SCLK rises or falls.
module spi_sclk_gen #(
    parameter int unsigned SCLK_DIV = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    output logic sclk,
    output logic rise_pulse_c,
    output logic fall_pulse_c
);

    localparam int unsigned CNT_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    logic [CNT_W-1:0] half_cnt;
    logic             half_end_c;

    assign half_end_c   = en && (half_cnt == CNT_W'(SCLK_DIV - 1));
    assign rise_pulse_c = half_end_c && !sclk;
    assign fall_pulse_c = half_end_c && sclk;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            half_cnt <= '0;
            sclk     <= 1'b0;
        end else if (!en) begin
            half_cnt <= '0;
            sclk     <= 1'b0;
        end else if (half_end_c) begin
            half_cnt <= '0;
            sclk     <= !sclk;
        end else begin
            half_cnt <= half_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_master.sv
// Initiator end of the 10-bit command SPI link: one command word per SS_n frame,
// with an 8-bit reply captured from MISO for read-data commands.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned SCLK_DIV  = 2,
    parameter int unsigned TURN_BITS = 2,
    parameter int unsigned IDLE_GAP  = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    input  logic [CMD_W-1:0]  cmd_data,
    output logic              cmd_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              SS_n,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int unsigned N_RD  = CMD_W + TURN_BITS + DATA_W;
    localparam int unsigned BIT_W = $clog2(N_RD + 1);
    localparam int unsigned GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

    spi_state_e        state_q, state_d;
    logic              accept_c;
    logic              active_q_c, active_d_c;
    logic              rise_c, fall_c;
    logic              rsp_done_c;
    logic [BIT_W-1:0]  bit_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [CMD_W-1:0]  tx_sh;
    logic [DATA_W-2:0] rx_sh;
    logic              is_rd_q;

    assign accept_c   = cmd_valid && cmd_ready;
    assign active_q_c = (state_q == ST_SHIFT_CMD) || (state_q == ST_TURN) || (state_q == ST_RECV);
    assign active_d_c = (state_d == ST_SHIFT_CMD) || (state_d == ST_TURN) || (state_d == ST_RECV);

    spi_sclk_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_sclk_gen (
        .clk          (clk),
        .rstn         (rstn),
        .en           (active_q_c),
        .sclk         (SCLK),
        .rise_pulse_c (rise_c),
        .fall_pulse_c (fall_c)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Phase changes happen on SCLK falls; bit_cnt already counts the bit being closed.
    always_comb begin
        state_d    = state_q;
        rsp_done_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) state_d = ST_SHIFT_CMD;
            end
            ST_SHIFT_CMD: begin
                if (fall_c && bit_cnt == BIT_W'(CMD_W)) begin
                    if (!is_rd_q)           state_d = ST_GAP;
                    else if (TURN_BITS > 0) state_d = ST_TURN;
                    else                    state_d = ST_RECV;
                end
            end
            ST_TURN: begin
                if (fall_c && bit_cnt == BIT_W'(CMD_W + TURN_BITS)) state_d = ST_RECV;
            end
            ST_RECV: begin
                if (fall_c && bit_cnt == BIT_W'(N_RD)) begin
                    state_d    = ST_GAP;
                    rsp_done_c = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_W'(IDLE_GAP - 1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Serial datapath and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmd_ready <= 1'b1;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            is_rd_q   <= 1'b0;
        end else begin
            cmd_ready <= (state_d == ST_IDLE);
            SS_n      <= !active_d_c;
            rsp_valid <= 1'b0;
            gap_cnt   <= (state_q == ST_GAP) ? gap_cnt + GAP_W'(1) : '0;
            if (accept_c) begin
                MOSI    <= cmd_data[CMD_W-1];
                tx_sh   <= {cmd_data[CMD_W-2:0], 1'b0};
                is_rd_q <= (cmd_data[CMD_W-1 -: TYPE_W] == CMD_RD_DATA);
                bit_cnt <= '0;
            end else begin
                if (rise_c) bit_cnt <= bit_cnt + BIT_W'(1);
                // tx_sh drains to zero, so MOSI reads 0 through turnaround and reply.
                if (fall_c) begin
                    MOSI  <= tx_sh[CMD_W-1];
                    tx_sh <= {tx_sh[CMD_W-2:0], 1'b0};
                end
                if (fall_c && state_q == ST_RECV) rx_sh <= {rx_sh[DATA_W-3:0], MISO};
                if (rsp_done_c) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= {rx_sh, MISO};
                end
                if (!active_d_c) MOSI <= 1'b0;
            end
        end
    end

endmodule
